// File: rtl/alu_issue_unit.sv
// Sequential issue front end for the 8-bit combinational ALU: accepts one instruction, repeats it count+1 times on the accumulator.
// Optional carry_flag output is enabled by defining ALU_ISSUE_CARRY_EN.
module alu_issue_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [WIDTH-1:0] instr_operand,
  input  logic [CNT_W-1:0] instr_count,
  input  logic             instr_load,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] acc,
  output logic             zero_flag,
  output logic             busy,
  output logic             done_valid
`ifdef ALU_ISSUE_CARRY_EN
  ,
  output logic             carry_flag
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] operand_reg;
  logic [CNT_W-1:0] rem;

  assign alu_a       = acc;
  assign alu_b       = operand_reg;
  assign alu_opcode  = op_reg;
  assign instr_ready = (state == S_IDLE);
  assign busy        = (state == S_RUN) || (state == S_DONE);

`ifdef ALU_ISSUE_CARRY_EN
  logic [WIDTH:0] add_ext;
  logic           carry_next;

  assign add_ext = {1'b0, acc} + {1'b0, operand_reg};

  always_comb begin
    carry_next = 1'b0;
    case (op_reg)
      4'b0000: carry_next = add_ext[WIDTH];
      4'b0001: carry_next = (acc < operand_reg);
      4'b1010: carry_next = (acc == '0);
      default: carry_next = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      acc         <= '0;
      op_reg      <= '0;
      operand_reg <= '0;
      rem         <= '0;
      zero_flag   <= 1'b1;
      done_valid  <= 1'b0;
`ifdef ALU_ISSUE_CARRY_EN
      carry_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done_valid <= 1'b0;
          if (instr_valid) begin
            op_reg      <= instr_op;
            operand_reg <= instr_operand;
            rem         <= instr_count;
            if (instr_load) begin
              acc        <= instr_operand;
              zero_flag  <= (instr_operand == '0);
              done_valid <= 1'b1;
              state      <= S_DONE;
`ifdef ALU_ISSUE_CARRY_EN
              carry_flag <= 1'b0;
`endif
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc       <= alu_y;
          zero_flag <= (alu_y == '0);
`ifdef ALU_ISSUE_CARRY_EN
          carry_flag <= carry_next;
`endif
          // The last step is the one taken with rem==0, so rem never wraps.
          if (rem == '0) begin
            done_valid <= 1'b1;
            state      <= S_DONE;
          end else begin
            rem <= rem - 1'b1;
          end
        end
        S_DONE: begin
          done_valid <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          done_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed self-checking bench for alu_issue_unit with a small behavioural ALU attached to the alu_* ports.
module tb_alu_issue_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [7:0] instr_operand;
  logic [2:0] instr_count;
  logic       instr_load;
  logic [7:0] alu_a, alu_b, alu_y, acc;
  logic [3:0] alu_opcode;
  logic       zero_flag, busy, done_valid;
`ifdef ALU_ISSUE_CARRY_EN
  logic       carry_flag;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_operand(instr_operand),
    .instr_count(instr_count), .instr_load(instr_load),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_y(alu_y),
    .acc(acc), .zero_flag(zero_flag), .busy(busy), .done_valid(done_valid)
`ifdef ALU_ISSUE_CARRY_EN
    , .carry_flag(carry_flag)
`endif
  );

  // External ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 NOT, 9 INC, A DEC; C..F return 0.
  always_comb begin
    alu_y = '0;
    case (alu_opcode)
      4'h0: alu_y = alu_a + alu_b;
      4'h1: alu_y = alu_a - alu_b;
      4'h2: alu_y = alu_a & alu_b;
      4'h3: alu_y = alu_a | alu_b;
      4'h4: alu_y = alu_a ^ alu_b;
      4'h5: alu_y = alu_a << 1;
      4'h6: alu_y = alu_a >> 1;
      4'h7: alu_y = ~alu_a;
      4'h9: alu_y = alu_a + 8'd1;
      4'hA: alu_y = alu_a - 8'd1;
      default: alu_y = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Presents an instruction and returns just after the accept edge; fields are scrambled afterwards.
  task automatic send(input logic ld, input logic [3:0] op, input logic [7:0] opnd, input logic [2:0] cnt);
    int unsigned guard;
    guard = 0;
    @(negedge clk);
    instr_load = ld; instr_op = op; instr_operand = opnd; instr_count = cnt;
    instr_valid = 1'b1;
    while (!instr_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_operand = ~opnd;
    instr_op = ~op;
    instr_count = ~cnt;
    instr_load = ~ld;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done_valid && lat < 40);
  endtask

  int lat;
  int low_cycles;
  int pulses;
  logic [7:0] exp_shl [4];
  logic [7:0] exp_dec [4];

  initial begin
    exp_shl[0] = 8'h01; exp_shl[1] = 8'h02; exp_shl[2] = 8'h04; exp_shl[3] = 8'h08;
    exp_dec[0] = 8'h02; exp_dec[1] = 8'h01; exp_dec[2] = 8'h00; exp_dec[3] = 8'hFF;
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_operand = '0;
    instr_count = '0; instr_load = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_acc", acc, 8'h00);
    check("rst_zero", zero_flag, 1);
    check("rst_done", done_valid, 0);
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
`ifdef ALU_ISSUE_CARRY_EN
    check("rst_carry", carry_flag, 0);
`endif
    rst_n = 1'b1;

    // Load 0x5A: done one cycle after accept, single-cycle pulse
    send(1'b1, 4'h0, 8'h5A, 3'd0);
    wait_done(lat);
    check("load_lat", lat, 1);
    check("load_acc", acc, 8'h5A);
    check("load_zero", zero_flag, 0);
    check("load_busy", busy, 1);
    @(negedge clk);
    check("load_pulse_end", done_valid, 0);
    check("load_ready", instr_ready, 1);

    // ADD with wrap
    send(1'b1, 4'h0, 8'hF0, 3'd0);
    wait_done(lat);
`ifdef ALU_ISSUE_CARRY_EN
    check("load_carry_clr", carry_flag, 0);
`endif
    send(1'b0, 4'h0, 8'h20, 3'd0);
    wait_done(lat);
    check("add_lat", lat, 2);
    check("add_acc", acc, 8'h10);
    check("add_zero", zero_flag, 0);
    check("add_alu_b", alu_b, 8'h20);
`ifdef ALU_ISSUE_CARRY_EN
    check("add_carry", carry_flag, 1);
`endif

    // SHL x3: acc sampled mid-cycle, each RUN edge shifts once
    send(1'b1, 4'h0, 8'h01, 3'd0);
    wait_done(lat);
    send(1'b0, 4'h5, 8'h00, 3'd2);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("shl_acc%0d", i), acc, exp_shl[i-1]);
      check($sformatf("shl_op%0d", i), alu_opcode, 4'h5);
      check($sformatf("shl_done%0d", i), done_valid, (i == 4) ? 1 : 0);
    end

    // DEC through zero
    send(1'b1, 4'h0, 8'h02, 3'd0);
    wait_done(lat);
    send(1'b0, 4'hA, 8'h00, 3'd2);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("dec_acc%0d", i), acc, exp_dec[i-1]);
    end
    check("dec_done", done_valid, 1);
    check("dec_zero", zero_flag, 0);
`ifdef ALU_ISSUE_CARRY_EN
    check("dec_carry", carry_flag, 1);
`endif

    // Handshake under busy: XOR x8 with a held OR behind it
    send(1'b1, 4'h0, 8'h30, 3'd0);
    wait_done(lat);
    send(1'b0, 4'h4, 8'h5A, 3'd7);
    instr_load = 1'b0; instr_op = 4'h3; instr_operand = 8'h0F; instr_count = 3'd0;
    instr_valid = 1'b1;
    low_cycles = 0;
    pulses = 0;
    @(negedge clk);
    while (!instr_ready && low_cycles < 40) begin
      low_cycles++;
      if (done_valid) pulses++;
      @(negedge clk);
    end
    check("hs_ready_low", low_cycles, 9);
    check("hs_pulses", pulses, 1);
    check("hs_xor_acc", acc, 8'h30);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    wait_done(lat);
    check("hs_or_lat", lat, 2);
    check("hs_or_acc", acc, 8'h3F);
    @(negedge clk);
    check("hs_idle_ready", instr_ready, 1);
    @(negedge clk);
    check("hs_once_acc", acc, 8'h3F);
    check("hs_once_busy", busy, 0);

`ifdef ALU_ISSUE_CARRY_EN
    send(1'b1, 4'h0, 8'h05, 3'd0);
    wait_done(lat);
    send(1'b0, 4'h1, 8'h07, 3'd0);
    wait_done(lat);
    check("sub_acc", acc, 8'hFE);
    check("sub_carry", carry_flag, 1);
    send(1'b1, 4'h0, 8'h3F, 3'd0);
    wait_done(lat);
`endif

    // Undefined opcode clears acc
    send(1'b0, 4'hC, 8'h11, 3'd0);
    wait_done(lat);
    check("undef_acc", acc, 8'h00);
    check("undef_zero", zero_flag, 1);
`ifdef ALU_ISSUE_CARRY_EN
    check("undef_carry", carry_flag, 0);
`endif

    // Maximum count: 8 shifts of 0x01 wrap to 0
    send(1'b1, 4'h0, 8'h01, 3'd0);
    wait_done(lat);
    send(1'b0, 4'h5, 8'h00, 3'd7);
    wait_done(lat);
    check("max_lat", lat, 9);
    check("max_acc", acc, 8'h00);
    check("max_zero", zero_flag, 1);

    // Reset during RUN
    send(1'b1, 4'h0, 8'h80, 3'd0);
    wait_done(lat);
    send(1'b0, 4'h6, 8'h00, 3'd5);
    repeat (3) @(negedge clk);
    check("mid_pre_acc", acc, 8'h20);
    rst_n = 1'b0;
    #1;
    check("mid_acc", acc, 8'h00);
    check("mid_zero", zero_flag, 1);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (done_valid) pulses++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done_valid) pulses++;
    end
    check("mid_no_done", pulses, 0);
    check("mid_ready", instr_ready, 1);
    check("mid_busy", busy, 0);
    check("mid_acc_after", acc, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
